// File: rtl/ddsm_pkg.sv
// ddsm_pkg: shared constants and helpers for the NC-DDSM datapath
package ddsm_pkg;
    localparam int Y_WIDTH = 4;
    localparam int Y_MIN   = -3;
    localparam int Y_MAX   = 4;

    // Enabled edges until every delay and history register holds real data
    function automatic int fill_len(input int skew);
        return 2 * skew + 3;
    endfunction
endpackage

// File: rtl/ddsm_delay_line.sv
// ddsm_delay_line: enable-gated shift register; a depth of zero is a plain wire
module ddsm_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused;
        assign unused = &{1'b0, i_clk, i_rst_n, i_en};
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] taps [DEPTH];
        // Shift one sample per enabled edge; everything holds while disabled
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
            end else if (i_en) begin
                taps[0] <= d;
                for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
            end
        end
        assign q = taps[DEPTH-1];
    end
endmodule

// File: rtl/mash_ecn.sv
// mash_ecn: MASH 1-1-1 error-cancellation network, aligns carries and forms c1 + (1-z^-1)c2 + (1-z^-1)^2 c3
module mash_ecn
    import ddsm_pkg::*;
#(
    parameter int P_SKEW = 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_c1,
    input  logic               i_c2,
    input  logic               i_c3,
    output logic [Y_WIDTH-1:0] o_y,
    output logic               o_valid
);
    localparam int P_Y_WIDTH = Y_WIDTH;
    localparam int P_FILL    = fill_len(P_SKEW);

    logic                 c1_r, c2_r, c3_r;
    logic                 a1, a2, a2p, a3p, a3pp;
    logic [3:0]           count;
    logic [P_Y_WIDTH-1:0] y_next;

    // Stage 1 waits for both later stages, stage 2 for stage 3
    ddsm_delay_line #(.DEPTH(2 * P_SKEW), .WIDTH(1)) u_dly_c1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .d       (c1_r),
        .q       (a1)
    );

    ddsm_delay_line #(.DEPTH(P_SKEW), .WIDTH(1)) u_dly_c2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .d       (c2_r),
        .q       (a2)
    );

    // Modular 4-bit sum; the result range -3..+4 always fits, so no saturation
    always_comb begin
        y_next = P_Y_WIDTH'(a1) + P_Y_WIDTH'(a2) - P_Y_WIDTH'(a2p)
               + P_Y_WIDTH'(c3_r) - (P_Y_WIDTH'(a3p) << 1) + P_Y_WIDTH'(a3pp);
    end

    // Capture carries, difference history and the output word on each enabled edge
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c1_r <= 1'b0;
            c2_r <= 1'b0;
            c3_r <= 1'b0;
            a2p  <= 1'b0;
            a3p  <= 1'b0;
            a3pp <= 1'b0;
            o_y  <= '0;
        end else if (i_en) begin
            c1_r <= i_c1;
            c2_r <= i_c2;
            c3_r <= i_c3;
            a2p  <= a2;
            a3p  <= c3_r;
            a3pp <= a3p;
            o_y  <= y_next;
        end
    end

    // Count enabled edges since reset, stopping once the pipeline is full
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) count <= '0;
        else if (i_en && count != 4'(P_FILL)) count <= count + 4'd1;
    end

    assign o_valid = (count == 4'(P_FILL));

    a_y_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        int'($signed(o_y)) >= Y_MIN && int'($signed(o_y)) <= Y_MAX);
endmodule

// File: tb/tb_mash_ecn.sv
// tb_mash_ecn: table-driven and randomized checks of mash_ecn at P_SKEW=1 and P_SKEW=0
module tb_mash_ecn;
    logic       clk, rst_n, en, c1, c2, c3;
    logic [3:0] y1, y0;
    logic       v1, v0;
    int         errors = 0;
    int         checks = 0;
    int         n = 0;
    int         kk = 0;
    bit         h1 [0:4095];
    bit         h2 [0:4095];
    bit         h3 [0:4095];

    typedef struct {
        bit         rst;
        bit         en;
        bit         c1, c2, c3;
        bit         chk;
        logic [3:0] y;
        bit         v;
    } vec_t;
    vec_t tbl[$];

    mash_ecn #(.P_SKEW(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_c1(c1), .i_c2(c2), .i_c3(c3), .o_y(y1), .o_valid(v1)
    );

    mash_ecn #(.P_SKEW(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .i_c1(c1), .i_c2(c2), .i_c3(c3), .o_y(y0), .o_valid(v0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t (edge %0d)", nm, act, exp, $time, n);
        end
    endtask

    // Carry sampled at enabled edge idx since reset; nothing exists before edge 1
    function automatic int hv(input int s, input int idx);
        if (idx < 1) return 0;
        return s == 1 ? int'(h1[idx]) : s == 2 ? int'(h2[idx]) : int'(h3[idx]);
    endfunction

    // Output after the n-th enabled edge from the transfer function and skew
    function automatic logic [3:0] model_y(input int s);
        int v;
        v = hv(3, n-1) - 2 * hv(3, n-2) + hv(3, n-3)
          + hv(2, n-1-s) - hv(2, n-2-s)
          + hv(1, n-1-2*s);
        return 4'(v);
    endfunction

    task automatic model_check();
        cmp("model_y_skew1", y1, model_y(1));
        cmp("model_v_skew1", {3'b0, v1}, {3'b0, n >= 5});
        cmp("model_y_skew0", y0, model_y(0));
        cmp("model_v_skew0", {3'b0, v0}, {3'b0, n >= 3});
    endtask

    task automatic step(input logic e, input logic a, input logic b, input logic c);
        en = e; c1 = a; c2 = b; c3 = c;
        @(posedge clk);
        if (e) begin
            n++;
            h1[n] = a; h2[n] = b; h3[n] = c;
        end
        #1;
        model_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("rst_y_skew1", y1, 4'h0);
        cmp("rst_v_skew1", {3'b0, v1}, 4'h0);
        cmp("rst_y_skew0", y0, 4'h0);
        cmp("rst_v_skew0", {3'b0, v0}, 4'h0);
        #2;
        rst_n = 1'b1;
        n = 0;
    endtask

    function automatic void row(input bit e, input bit a, input bit b, input bit c,
                                input bit ck, input logic [3:0] ey);
        vec_t r;
        if (e) kk++;
        r.rst = 0; r.en = e; r.c1 = a; r.c2 = b; r.c3 = c;
        r.chk = ck; r.y = ey; r.v = (kk >= 5);
        tbl.push_back(r);
    endfunction

    function automatic void rrow();
        vec_t r;
        kk = 0;
        r.rst = 1; r.en = 0; r.c1 = 0; r.c2 = 0; r.c3 = 0;
        r.chk = 1; r.y = 4'h0; r.v = 0;
        tbl.push_back(r);
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;

        // Reset/fill and c3 impulse at edge 10
        rrow();
        for (int k = 1; k <= 15; k++)
            row(1, 0, 0, k == 10, 1, k == 11 ? 4'h1 : k == 12 ? 4'hE : k == 13 ? 4'h1 : 4'h0);
        // c2 impulse at edge 10, c1 impulse at edge 20
        rrow();
        for (int k = 1; k <= 25; k++)
            row(1, k == 20, k == 10, 0, 1, k == 12 ? 4'h1 : k == 13 ? 4'hF : k == 23 ? 4'h1 : 4'h0);
        // Maximum: a1=1, a2 0->1, a3 1,0,1 aligned at edge 13
        rrow();
        for (int k = 1; k <= 14; k++)
            row(1, k == 10, k == 11, k == 10 || k == 12, k == 13, 4'h4);
        // Minimum: a1=0, a2 1->0, a3 0,1,0 aligned at edge 13
        rrow();
        for (int k = 1; k <= 14; k++)
            row(1, 0, k == 10, k == 11, k == 13, 4'hD);
        // Constant all-ones settles to +1
        rrow();
        for (int k = 1; k <= 10; k++)
            row(1, 1, 1, 1, k >= 5, 4'h1);
        // Mid-stream reset after all-ones, then c3 impulse with a 3-cycle stall
        rrow();
        for (int k = 1; k <= 12; k++)
            row(1, 0, 0, k == 10, k >= 11, k == 11 ? 4'h1 : 4'hE);
        for (int k = 0; k < 3; k++)
            row(0, 0, 0, 0, 1, 4'hE);
        row(1, 0, 0, 0, 1, 4'h1);
        row(1, 0, 0, 0, 1, 4'h0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset();
            end else begin
                step(tbl[i].en, tbl[i].c1, tbl[i].c2, tbl[i].c3);
                if (tbl[i].chk) cmp($sformatf("tbl_y[%0d]", i), y1, tbl[i].y);
                cmp($sformatf("tbl_v[%0d]", i), {3'b0, v1}, {3'b0, tbl[i].v});
            end
        end

        // P_SKEW=0: c2 impulse at edge 10 appears after edge 11; fill takes 3 edges
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step(1, 0, k == 10, 0);
            if (k == 2)  cmp("skew0_v_edge2", {3'b0, v0}, 4'h0);
            if (k == 3)  cmp("skew0_v_edge3", {3'b0, v0}, 4'h1);
            if (k == 11) cmp("skew0_c2_edge11", y0, 4'h1);
            if (k == 12) cmp("skew0_c2_edge12", y0, 4'hF);
        end

        // Random carries, enable gaps and occasional resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step($urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mash_ecn.md
# mash_ecn

MASH 1-1-1 error-cancellation network for the NC-DDSM datapath. It takes the three 1-bit carry streams from the cascaded pipelined accumulator stages and re-aligns the pipeline skew between them. It then combines them as y = c1 + (1−z⁻¹)·c2 + (1−z⁻¹)²·c3 into a signed multi-level divider-control word. It sits directly after the third accumulator and drives the divider modulus input.

## Interface
Parameters:
- P_SKEW, default 1: cycles by which each accumulator stage's carry lags the previous stage's carry; legal values 0..4.
- P_Y_WIDTH, default 4: output width; fixed at 4 and held as a package constant, not overridable per instance.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset; asynchronous, active-low.
- i_en, input, 1: clock enable; when low, every register in the block holds its value.
- i_c1, input, 1: carry from accumulator stage 1.
- i_c2, input, 1: carry from accumulator stage 2; lags i_c1 by P_SKEW cycles.
- i_c3, input, 1: carry from accumulator stage 3; lags i_c2 by P_SKEW cycles.
- o_y, output, 4: signed two's-complement result in the range −3..+4.
- o_valid, output, 1: high once the delay and history registers hold real data.

## Operation
- Input stage:
  - i_c1, i_c2 and i_c3 are registered on every enabled edge.
- Alignment:
  - Registered c1 passes through a 2·P_SKEW-deep delay line to give a1.
  - Registered c2 passes through a P_SKEW-deep delay line to give a2.
  - Registered c3 is used directly as a3.
  - A depth of 0 is a wire.
- History: a2 keeps one previous sample (a2p); a3 keeps two previous samples (a3p, a3pp).
- Arithmetic, evaluated at 4-bit signed width with no saturation:
  - d2 = a2 − a2p, range −1..+1.
  - d3 = a3 − 2·a3p + a3pp, range −2..+2.
  - y = a1 + d2 + d3, range −3..+4.
  - Every term is zero- or sign-extended to 4 bits before summing; there is no overflow path.
- Output: y is registered into o_y on each enabled edge.
- Fill counter:
  - Counts enabled edges since reset and saturates at P_FILL = 2·P_SKEW + 3.
  - o_valid = (count == P_FILL). Once high, it stays high until reset.
- Enable: when i_en is low, all delay lines, history registers, the counter, o_y and o_valid hold; no sample is lost or duplicated.
- Reset:
  - Asserting reset, including mid-stream, clears every register.
  - o_y = 4'b0000 and o_valid = 0 while reset is asserted and immediately after release.
  - The fill count restarts from 0 after release.
- o_y is driven during fill as well. Downstream logic gates on o_valid.

## Timing
- Latency: for stream ck sampled at enabled edge j, its contribution appears on o_y after the following enabled edge.
  - c3 (k = 3): edge j+1.
  - c2 (k = 2): edge j+P_SKEW+1.
  - c1 (k = 1): edge j+2·P_SKEW+1.
- Difference taps: the −2·a3p and −a2p terms land one enabled edge after the original sample's contribution; a3pp lands two enabled edges after.
- Throughput: one result per enabled cycle; no backpressure.
- o_valid first rises on the P_FILL-th enabled edge after reset release.

## Structure
- Shared package ddsm_pkg holds:
  - Y_WIDTH = 4.
  - Y_MIN = −3 and Y_MAX = +4, for assertions.
  - A function computing P_FILL from P_SKEW.
- One sub-module, ddsm_delay_line:
  - Parameterised depth (0 allowed) and width.
  - Has i_en and asynchronous active-low reset.
  - Instantiated twice, for c1 and c2 alignment.
- Everything else (history registers, adder, fill counter, output register) is in mash_ecn.

## Test plan
All scenarios use P_SKEW=1 unless noted; i_en is held at 1 except in scenario 5.
1. Reset and fill:
   - Stimulus: all carries at 0, reset released.
   - Required: o_y = 0 throughout; o_valid = 0 for the first 4 enabled edges and 1 from the 5th edge onward.
2. c3 impulse: i_c3 = 1 at edge 10 only → o_y = +1, −2, +1 after edges 11, 12, 13, then 0.
3. c2 and c1 impulses:
   - i_c2 = 1 at edge 10 only → o_y = +1 after edge 12, −1 after edge 13, then 0.
   - i_c1 = 1 at edge 20 only → o_y = +1 after edge 23 only.
4. Extremes:
   - Drive aligned samples a1=1, a2 0→1, a3 1,0,1 → o_y = 4'b0100 (+4).
   - Drive aligned samples a1=0, a2 1→0, a3 0,1,0 → o_y = 4'b1101 (−3).
   - Constant all-ones input → o_y settles to +1.
5. Enable gating:
   - Stimulus: c3 impulse as in scenario 2, with i_en low for 3 cycles between the −2 and +1 outputs.
   - Required: o_y holds −2 through the stall, then +1 on the next enabled edge; o_valid is unaffected.
6. Reset mid-stream and P_SKEW=0:
   - Assert i_rst_n low mid-sequence → o_y = 0 and o_valid = 0 immediately (asynchronous); refill takes 5 edges.
   - Repeat scenario 3 with P_SKEW=0 → c2 impulse at edge 10 appears after edge 11, and P_FILL = 3.
